// File: rtl/vlc_pkg.sv
// Shared definitions for the VLC bitstream packers: accumulator and word
// geometry, the packer control state, and a bit-to-byte rounding helper.
package vlc_pkg;

  localparam int ACC_W    = 128;  // pending-bit accumulator width
  localparam int OUT_W    = 64;   // emitted word width
  localparam int MAX_CODE = 64;   // longest code accepted per cycle
  localparam int PEND_W   = 7;    // width of the pending-bit counter (0..127)

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Number of bytes needed to hold 'bits' bits once padded to a byte boundary.
  function automatic logic [4:0] bytes_for_bits(input logic [7:0] bits);
    return 5'((bits + 8'd7) >> 3);
  endfunction

endpackage

// File: rtl/vlc_bit_align.sv
// Combinational masked merge: places the low size_i bits of val_i directly
// after the cnt_i pending bits held left-aligned in acc_i. Bits of acc_i below
// the pending region are expected to be zero.
module vlc_bit_align
  import vlc_pkg::*;
(
  input  logic [ACC_W-1:0]    acc_i,
  input  logic [PEND_W-1:0]   cnt_i,
  input  logic [MAX_CODE-1:0] val_i,
  input  logic [PEND_W-1:0]   size_i,
  output logic [ACC_W-1:0]    acc_o
);

  logic [MAX_CODE-1:0] mask;
  logic [ACC_W-1:0]    code_ext;
  logic [7:0]          shamt;

  // Mask the code, then shift it so its MSB lands right after the pending bits.
  always_comb begin
    // size_i[6] set means a full 64-bit code, which needs no masking
    mask     = size_i[6] ? '1 : ((MAX_CODE'(1) << size_i[5:0]) - MAX_CODE'(1));
    code_ext = {{(ACC_W-MAX_CODE){1'b0}}, val_i & mask};
    // cnt_i + size_i never exceeds 127, so the shift is always 1..128
    shamt    = 8'(ACC_W) - {1'b0, cnt_i} - {1'b0, size_i};
    acc_o    = acc_i | (code_ext << shamt);
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// VLC bitstream packer: concatenates 0..64-bit codes MSB-first into 64-bit
// big-endian words, byte-aligns and drains the tail on flush, and tracks the
// byte count of the current slice.
// Optional build macro VLC_BIT_PACKER_SIZE_CHECK_EN: clamps oversize code
// lengths to 64 bits and flags them on err.
module vlc_bit_packer
  import vlc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_enable,
  input  logic [MAX_CODE-1:0] in_val,
  input  logic [63:0]         in_size,
  input  logic                in_flush,
  output logic                out_valid,
  output logic [OUT_W-1:0]    out_word,
  output logic [3:0]          out_bytes,
  output logic                out_last,
  output logic                busy,
  output logic [CNT_W-1:0]    byte_count,
  output logic                err
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PEND_W-1:0]  cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_word_q, out_word_d;
  logic [3:0]         out_bytes_q, out_bytes_d;
  logic               out_last_q, out_last_d;
  logic [CNT_W-1:0]   byte_count_q, byte_count_d;
  logic               err_q, err_d;
  logic               slice_done_q, slice_done_d;

  logic [PEND_W-1:0]  size_eff;
  logic               size_bad;
  logic [PEND_W-1:0]  app_size;
  logic [ACC_W-1:0]   merged;
  logic [7:0]         new_cnt;
  logic [4:0]         padded_bytes;

`ifdef VLC_BIT_PACKER_SIZE_CHECK_EN
  // Clamp any length above 64 to a full 64-bit code and flag it.
  always_comb begin
    size_bad = (|in_size[63:7]) || (in_size[6:0] > 7'(MAX_CODE));
    size_eff = size_bad ? 7'(MAX_CODE) : in_size[6:0];
  end
`else
  logic unused_size_hi;
  assign unused_size_hi = ^in_size[63:7];
  assign size_bad       = 1'b0;
  assign size_eff       = in_size[6:0];
`endif

  assign app_size     = in_enable ? size_eff : '0;
  assign new_cnt      = {1'b0, cnt_q} + {1'b0, app_size};
  assign padded_bytes = bytes_for_bits(new_cnt);

  vlc_bit_align u_align (
    .acc_i  (acc_q),
    .cnt_i  (cnt_q),
    .val_i  (in_val),
    .size_i (app_size),
    .acc_o  (merged)
  );

  // Next-state and registered-output decode for append, emit and flush.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_word_d   = '0;
    out_bytes_d  = '0;
    out_last_d   = 1'b0;
    err_d        = err_q;
    byte_count_d = byte_count_q;
    slice_done_d = slice_done_q;

    case (state_q)
      RUN: begin
        if (in_enable && size_bad) err_d = 1'b1;
        if (in_flush) begin
          if (padded_bytes == 5'd0) begin
            out_last_d = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
          end else if (padded_bytes <= 5'd8) begin
            out_valid_d = 1'b1;
            out_word_d  = merged[ACC_W-1 -: OUT_W];
            out_bytes_d = padded_bytes[3:0];
            out_last_d  = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            // Tail spans two words: emit the first now, the rest from FLUSH.
            out_valid_d = 1'b1;
            out_word_d  = merged[ACC_W-1 -: OUT_W];
            out_bytes_d = 4'd8;
            acc_d       = merged << OUT_W;
            cnt_d       = PEND_W'(new_cnt - 8'(OUT_W));
            state_d     = FLUSH;
          end
        end else if (new_cnt >= 8'(OUT_W)) begin
          out_valid_d = 1'b1;
          out_word_d  = merged[ACC_W-1 -: OUT_W];
          out_bytes_d = 4'd8;
          acc_d       = merged << OUT_W;
          cnt_d       = PEND_W'(new_cnt - 8'(OUT_W));
        end else begin
          acc_d = merged;
          cnt_d = new_cnt[PEND_W-1:0];
        end
      end

      FLUSH: begin
        if (in_enable || in_flush) err_d = 1'b1;
        out_valid_d = 1'b1;
        out_word_d  = acc_q[ACC_W-1 -: OUT_W];
        out_bytes_d = 4'(bytes_for_bits({1'b0, cnt_q}));
        out_last_d  = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = RUN;
      end
    endcase

    // The first word after a finished slice restarts the byte count.
    if (out_valid_d) begin
      byte_count_d = (slice_done_q ? '0 : byte_count_q) + CNT_W'(out_bytes_d);
      slice_done_d = 1'b0;
    end
    if (out_last_d) slice_done_d = 1'b1;
  end

  // State and output registers; reset discards any partial slice.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      out_bytes_q  <= '0;
      out_last_q   <= 1'b0;
      byte_count_q <= '0;
      err_q        <= 1'b0;
      slice_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_bytes_q  <= out_bytes_d;
      out_last_q   <= out_last_d;
      byte_count_q <= byte_count_d;
      err_q        <= err_d;
      slice_done_q <= slice_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_bytes  = out_bytes_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q == FLUSH);
  assign byte_count = byte_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Testbench for vlc_bit_packer: directed vector table, hand-written reset
// corner case, and random stimulus against a bit-queue reference model.
// Optional build macro VLC_BIT_PACKER_SIZE_CHECK_EN adds the clamp test.
module tb_vlc_bit_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_enable = 1'b0;
  logic [63:0] in_val = '0;
  logic [63:0] in_size = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic [63:0] out_word;
  logic [3:0]  out_bytes;
  logic        out_last;
  logic        busy;
  logic [31:0] byte_count;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the pending stream as a queue of bits, first bit at front.
  bit          m_bits[$];
  bit          m_busy;
  logic [63:0] m_rem_word;
  int          m_rem_bytes;
  int          m_bc;
  bit          m_done;
  bit          m_err;

  logic        e_valid;
  logic [63:0] e_word;
  int          e_bytes;
  bit          e_last;

  typedef struct {
    logic        en;
    logic [63:0] val;
    int          size;
    logic        fl;
    logic        v;
    logic [63:0] w;
    int          b;
    logic        l;
    logic        bsy;
    int          bc;
  } vec_t;

  vec_t vecs[12];

  vlc_bit_packer #(.CNT_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_enable  (in_enable),
    .in_val     (in_val),
    .in_size    (in_size),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .out_bytes  (out_bytes),
    .out_last   (out_last),
    .busy       (busy),
    .byte_count (byte_count),
    .err        (err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_busy = 0; m_rem_word = '0; m_rem_bytes = 0;
    m_bc = 0; m_done = 0; m_err = 0;
  endtask

  task automatic pop_word(input int n, output logic [63:0] w);
    w = '0;
    for (int k = 0; k < n; k++) w[63-k] = m_bits.pop_front();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_word"}, out_word, 0);
    check({tag, "_bytes"}, out_bytes, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bc"}, byte_count, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    in_enable = 0; in_val = '0; in_size = '0; in_flush = 0;
    reset_n = 0;
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    check_all_zero("reset");
    reset_n = 1;
  endtask

  // Drive one cycle of input, advance the model, then compare after the edge.
  task automatic step(input logic en, input logic [63:0] val, input int size, input logic fl);
    int total;
    in_enable = en; in_val = val; in_size = 64'(size); in_flush = fl;
    e_valid = 0; e_word = '0; e_bytes = 0; e_last = 0;
    if (m_busy) begin
      if (en || fl) m_err = 1;
      e_valid = 1; e_word = m_rem_word; e_bytes = m_rem_bytes; e_last = 1;
      m_busy = 0;
    end else begin
      if (en) for (int i = size - 1; i >= 0; i--) m_bits.push_back(val[i]);
      if (fl) begin
        while (m_bits.size() % 8 != 0) m_bits.push_back(1'b0);
        total = m_bits.size();
        if (total == 0) begin
          e_last = 1;
        end else if (total <= 64) begin
          e_valid = 1; e_bytes = total / 8; e_last = 1;
          pop_word(total, e_word);
        end else begin
          e_valid = 1; e_bytes = 8;
          pop_word(64, e_word);
          m_rem_bytes = (total - 64) / 8;
          pop_word(total - 64, m_rem_word);
          m_busy = 1;
        end
      end else if (m_bits.size() >= 64) begin
        e_valid = 1; e_bytes = 8;
        pop_word(64, e_word);
      end
    end
    if (e_valid) begin
      m_bc = (m_done ? 0 : m_bc) + e_bytes;
      m_done = 0;
    end
    if (e_last) m_done = 1;

    @(posedge clock); #1;
    check("out_valid", out_valid, e_valid);
    check("out_word", out_word, e_word);
    check("out_bytes", out_bytes, e_bytes);
    check("out_last", out_last, e_last);
    check("busy", busy, m_busy);
    check("byte_count", byte_count, m_bc);
    check("err", err, m_err);
  endtask

  logic        r_en, r_fl;
  logic [63:0] r_val;
  int          r_size, r_sel;

  initial begin
    // Directed vectors: {en, val, size, flush, valid, word, bytes, last, busy, byte_count}
    vecs[0]  = '{1'b1, 64'h5, 3, 1'b0,  1'b0, 64'h0, 0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 64'h1, 1, 1'b0,  1'b0, 64'h0, 0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 64'h0, 0, 1'b1,  1'b1, 64'hB000000000000000, 1, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, 64'hDEADBEEFCAFEF00D, 64, 1'b0,  1'b1, 64'hDEADBEEFCAFEF00D, 8, 1'b0, 1'b0, 8};
    vecs[4]  = '{1'b0, 64'h0, 0, 1'b1,  1'b0, 64'h0, 0, 1'b1, 1'b0, 8};
    vecs[5]  = '{1'b1, 64'h0, 60, 1'b0,  1'b0, 64'h0, 0, 1'b0, 1'b0, 8};
    vecs[6]  = '{1'b1, 64'h3FF, 10, 1'b0,  1'b1, 64'h000000000000000F, 8, 1'b0, 1'b0, 8};
    vecs[7]  = '{1'b0, 64'h0, 0, 1'b1,  1'b1, 64'hFC00000000000000, 1, 1'b1, 1'b0, 9};
    vecs[8]  = '{1'b1, 64'h00ABCDEF01234567, 56, 1'b0,  1'b0, 64'h0, 0, 1'b0, 1'b0, 9};
    vecs[9]  = '{1'b1, 64'h0123456789ABCDEF, 64, 1'b1,  1'b1, 64'hABCDEF0123456701, 8, 1'b0, 1'b1, 8};
    vecs[10] = '{1'b1, 64'hFF, 8, 1'b0,  1'b1, 64'h23456789ABCDEF00, 7, 1'b1, 1'b0, 15};
    vecs[11] = '{1'b0, 64'h0, 0, 1'b0,  1'b0, 64'h0, 0, 1'b0, 1'b0, 15};

    do_reset();
    for (int n = 0; n < 12; n++) begin
      step(vecs[n].en, vecs[n].val, vecs[n].size, vecs[n].fl);
      check($sformatf("vec%0d_valid", n), out_valid, vecs[n].v);
      check($sformatf("vec%0d_word", n), out_word, vecs[n].w);
      check($sformatf("vec%0d_bytes", n), out_bytes, vecs[n].b);
      check($sformatf("vec%0d_last", n), out_last, vecs[n].l);
      check($sformatf("vec%0d_busy", n), busy, vecs[n].bsy);
      check($sformatf("vec%0d_bc", n), byte_count, vecs[n].bc);
    end
    check("err_after_busy_input", err, 1);

    // Reset asserted while draining: outputs clear at once, nothing follows.
    do_reset();
    step(1'b1, 64'h00FFFFFFFFFFFFFF, 56, 1'b0);
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64, 1'b1);
    check("pre_reset_busy", busy, 1);
    #2 reset_n = 0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clock); #1;
    reset_n = 1;
    step(1'b0, 64'h0, 0, 1'b0);
    step(1'b0, 64'h0, 0, 1'b0);

`ifdef VLC_BIT_PACKER_SIZE_CHECK_EN
    do_reset();
    in_enable = 1; in_val = '1; in_size = 64'd70; in_flush = 0;
    @(posedge clock); #1;
    check("clamp_valid", out_valid, 1);
    check("clamp_word", out_word, 64'hFFFFFFFFFFFFFFFF);
    check("clamp_bytes", out_bytes, 8);
    check("clamp_err", err, 1);
`endif

    // Random stimulus against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_fl  = ($urandom_range(0, 11) == 0);
      r_val = {$urandom(), $urandom()};
      r_sel = $urandom_range(0, 9);
      if (r_sel == 0)      r_size = 0;
      else if (r_sel <= 2) r_size = 64;
      else                 r_size = $urandom_range(1, 63);
      step(r_en, r_val, r_size, r_fl);
    end
    step(1'b0, 64'h0, 0, 1'b1);
    step(1'b0, 64'h0, 0, 1'b0);
    step(1'b0, 64'h0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
